// File: rtl/cfu_simd_mac_accbuf.sv
// cfu_simd_mac_accbuf: int8 SIMD MAC custom-instruction unit with filter bank and
// an int32 accumulation buffer swept to zero on reset or on request.
module cfu_simd_mac_accbuf #(
   parameter int INPUT_OFFSET = 128,
   parameter int FILTER_WORDS = 8,
   parameter int ACC_ROWS     = 28,
   parameter int ACC_COLS     = 28
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_payload_function_id,
   input  logic [31:0] cmd_payload_inputs_0,
   input  logic [31:0] cmd_payload_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_payload_outputs_0
);
   localparam int N  = ACC_ROWS * ACC_COLS;
   localparam int IW = $clog2(N);
   localparam int PW = $clog2(FILTER_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_CLEAR, S_RESP} state_t;

   state_t             r_state;
   logic [IW-1:0]      r_cidx;
   logic               r_clr_rsp;
   logic [31:0]        r_rsp;
   logic [31:0]        r_sum;
   logic [PW-1:0]      r_ptr;
   logic               r_err;
   logic [31:0]        r_filt [FILTER_WORDS];
   logic signed [16:0] r_prod [8];
   logic [31:0]        r_buf [N];

   logic signed [16:0] w_prod [8];
   logic signed [19:0] w_dot;
   logic [63:0]        w_ops, w_wts;
   logic [PW-1:0]      w_ptr1, w_ptr2, w_fidx, w_pset;
   logic [IW-1:0]      w_idx, w_widx;
   logic               w_inr, w_bufop, w_we;
   logic [31:0]        w_rd, w_acc, w_wd, w_new_sum;

   assign cmd_ready             = r_state == S_IDLE;
   assign rsp_valid             = r_state == S_RESP;
   assign rsp_payload_outputs_0 = r_rsp;

   assign w_ptr1 = (r_ptr == PW'(FILTER_WORDS - 1)) ? '0 : r_ptr + 1'b1;
   assign w_ptr2 = PW'((32'(r_ptr) + 32'd2) % FILTER_WORDS);
   assign w_fidx = PW'(cmd_payload_inputs_1 % FILTER_WORDS);
   assign w_pset = PW'(cmd_payload_inputs_0 % FILTER_WORDS);
   assign w_ops  = {cmd_payload_inputs_1, cmd_payload_inputs_0};
   assign w_wts  = {r_filt[w_ptr1], r_filt[r_ptr]};

   for (genvar k = 0; k < 8; k++) begin : g_lane
      logic signed [8:0] w_ao;
      assign w_ao      = 9'($signed(w_ops[8*k +: 8]) + INPUT_OFFSET);
      assign w_prod[k] = w_ao * $signed(w_wts[8*k +: 8]);
   end

   always_comb begin
      w_dot = '0;
      for (int k = 0; k < 8; k++) w_dot = w_dot + 20'(r_prod[k]);
   end
   assign w_new_sum = r_sum + 32'(w_dot);

   // Row/column bounds use the full operand width; the linear index is only trusted when in range
   assign w_inr  = (cmd_payload_inputs_0 < 32'(ACC_ROWS)) && (cmd_payload_inputs_1 < 32'(ACC_COLS));
   assign w_idx  = cmd_payload_inputs_0[IW-1:0] * IW'(ACC_COLS) + cmd_payload_inputs_1[IW-1:0];
   assign w_rd   = r_buf[w_idx];
   assign w_acc  = w_rd + r_sum;
   assign w_bufop = cmd_ready && cmd_valid &&
                    (cmd_payload_function_id == 10'd17 || cmd_payload_function_id == 10'd18);
   assign w_we   = (r_state == S_CLEAR) || (w_bufop && w_inr);
   assign w_widx = (r_state == S_CLEAR) ? r_cidx : w_idx;
   assign w_wd   = (r_state != S_CLEAR && cmd_payload_function_id[0]) ? w_acc : '0;

   always_ff @(posedge clk) begin
      if (w_we) r_buf[w_widx] <= w_wd;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_CLEAR;
         r_cidx    <= '0;
         r_clr_rsp <= 1'b0;
         r_rsp     <= '0;
         r_sum     <= '0;
         r_ptr     <= '0;
         r_err     <= 1'b0;
         r_filt    <= '{default: '0};
         r_prod    <= '{default: '0};
      end else begin
         case (r_state)
            S_IDLE: if (cmd_valid) begin
               r_rsp   <= '0;
               r_state <= S_RESP;
               case (cmd_payload_function_id)
                  10'd0: begin
                     r_sum <= '0;
                     r_ptr <= '0;
                  end
                  10'd1: begin
                     r_prod  <= w_prod;
                     r_state <= S_MAC;
                  end
                  10'd2: r_rsp <= r_sum;
                  10'd3: begin
                     r_rsp <= {31'b0, r_err};
                     r_err <= 1'b0;
                  end
                  10'd8:  r_filt <= '{default: '0};
                  10'd9:  r_filt[w_fidx] <= cmd_payload_inputs_0;
                  10'd10: r_ptr <= w_pset;
                  10'd16: begin
                     r_cidx    <= '0;
                     r_clr_rsp <= 1'b1;
                     r_state   <= S_CLEAR;
                  end
                  10'd17, 10'd18: begin
                     r_rsp <= !w_inr ? 32'h8000_0000 : cmd_payload_function_id[0] ? w_acc : w_rd;
                     if (!w_inr) r_err <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MAC: begin
               r_sum   <= w_new_sum;
               r_rsp   <= w_new_sum;
               r_ptr   <= w_ptr2;
               r_state <= S_RESP;
            end
            S_CLEAR: begin
               r_cidx <= r_cidx + 1'b1;
               if (r_cidx == IW'(N - 1)) begin
                  r_state   <= r_clr_rsp ? S_RESP : S_IDLE;
                  r_rsp     <= '0;
                  r_clr_rsp <= 1'b0;
               end
            end
            default: if (rsp_ready) r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cfu_simd_mac_accbuf.sv
// tb_cfu_simd_mac_accbuf: randomized and directed checks of the SIMD MAC / accumulation buffer CFU
// against an array-based reference model.
module tb_cfu_simd_mac_accbuf;
   localparam int R = 28, C = 28, FW = 8, OFF = 128;

   typedef struct {
      logic [9:0]  f;
      logic [31:0] a, b, e;
      int          lat;
   } vec_t;

   logic        clk = 0, reset = 0, cmd_valid = 0, rsp_ready = 1;
   logic [9:0]  fn = '0;
   logic [31:0] in0 = '0, in1 = '0;
   logic        cmd_ready, rsp_valid;
   logic [31:0] rsp_out;

   int n_cmp = 0, n_bad = 0;

   logic [31:0] m_filt [FW];
   logic [31:0] m_buf [R][C];
   logic [31:0] m_sum;
   int          m_ptr;
   logic        m_err;

   always #5 clk = ~clk;

   cfu_simd_mac_accbuf dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_payload_function_id(fn), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_out)
   );

   task automatic model_reset;
      m_sum = 0; m_ptr = 0; m_err = 0;
      for (int i = 0; i < FW; i++) m_filt[i] = 0;
      for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) m_buf[i][j] = 0;
   endtask

   function automatic logic [31:0] ref_dot(input logic [31:0] a0, input logic [31:0] a1);
      logic [31:0] w0, w1;
      int s;
      w0 = m_filt[m_ptr];
      w1 = m_filt[(m_ptr + 1) % FW];
      s = 0;
      for (int k = 0; k < 4; k++)
         s += (int'($signed(a0[8*k +: 8])) + OFF) * int'($signed(w0[8*k +: 8]))
            + (int'($signed(a1[8*k +: 8])) + OFF) * int'($signed(w1[8*k +: 8]));
      return s;
   endfunction

   task automatic model_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] e, output int lat);
      e = 0; lat = 1;
      case (f)
         10'd0: begin m_sum = 0; m_ptr = 0; end
         10'd1: begin
            m_sum = m_sum + ref_dot(a, b);
            m_ptr = (m_ptr + 2) % FW;
            e = m_sum; lat = 2;
         end
         10'd2: e = m_sum;
         10'd3: begin e = {31'b0, m_err}; m_err = 0; end
         10'd8: for (int i = 0; i < FW; i++) m_filt[i] = 0;
         10'd9: m_filt[b % FW] = a;
         10'd10: m_ptr = int'(a % FW);
         10'd16: begin
            for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) m_buf[i][j] = 0;
            lat = R * C + 1;
         end
         10'd17, 10'd18: begin
            if (a >= R || b >= C) begin e = 32'h8000_0000; m_err = 1; end
            else if (f == 10'd17) begin m_buf[a][b] = m_buf[a][b] + m_sum; e = m_buf[a][b]; end
            else begin e = m_buf[a][b]; m_buf[a][b] = 0; end
         end
         default: ;
      endcase
   endtask

   task automatic do_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
      int g;
      @(negedge clk);
      fn = f; in0 = a; in1 = b; cmd_valid = 1; rsp_ready = 1;
      g = 0;
      while (!cmd_ready && g < 2000) begin @(negedge clk); g++; end
      @(posedge clk); #1;
      cmd_valid = 0;
      lat = 1;
      while (!rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
      r = rsp_out;
      @(posedge clk); #1;
   endtask

   task automatic start(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      fn = f; in0 = a; in1 = b; cmd_valid = 1; rsp_ready = 0;
      @(posedge clk); #1;
      cmd_valid = 0;
   endtask

   task automatic test_reset;
      int cyc;
      logic saw;
      @(negedge clk);
      reset = 0; cmd_valid = 0;
      repeat (2) @(negedge clk);
      n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", cmd_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      n_cmp++; if (rsp_out !== 32'h0) begin n_bad++; $display("FAIL reset_payload got %h want 0", rsp_out); end
      reset = 1; cyc = 0; saw = 0;
      while (!cmd_ready && cyc < 2000) begin @(posedge clk); #1; cyc++; saw |= rsp_valid; end
      n_cmp++; if (cyc != R * C) begin n_bad++; $display("FAIL reset_sweep_cycles got %0d want %0d", cyc, R * C); end
      n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL reset_no_rsp got %b want 0", saw); end
      model_reset;
   endtask

   task automatic test_mac;
      vec_t v[11];
      logic [31:0] r, me;
      int lat, ml;
      v = '{'{10'd9, 32'h01010101, 32'd0, 32'd0, 1}, '{10'd9, 32'h02020202, 32'd1, 32'd0, 1},
            '{10'd0, 32'd0, 32'd0, 32'd0, 1},
            '{10'd1, 32'd0, 32'h80808080, 32'd512, 2}, '{10'd1, 32'd0, 32'h80808080, 32'd512, 2},
            '{10'd1, 32'd0, 32'h80808080, 32'd512, 2}, '{10'd1, 32'd0, 32'h80808080, 32'd512, 2},
            '{10'd1, 32'd0, 32'h80808080, 32'd1024, 2}, '{10'd2, 32'd0, 32'd0, 32'd1024, 1},
            '{10'd3, 32'd0, 32'd0, 32'd0, 1}, '{10'd4, 32'd5, 32'd5, 32'd0, 1}};
      for (int i = 0; i < 11; i++) begin
         do_cmd(v[i].f, v[i].a, v[i].b, r, lat);
         model_cmd(v[i].f, v[i].a, v[i].b, me, ml);
         n_cmp++; if (r !== v[i].e) begin n_bad++; $display("FAIL mac[%0d] rsp got %h want %h", i, r, v[i].e); end
         n_cmp++; if (lat != v[i].lat) begin n_bad++; $display("FAIL mac[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      end
   endtask

   task automatic test_buffer;
      vec_t v[6];
      logic [31:0] r, me;
      int lat, ml;
      v = '{'{10'd0, 32'd0, 32'd0, 32'd0, 1}, '{10'd1, 32'd0, 32'h80808080, 32'd512, 2},
            '{10'd17, 32'd3, 32'd5, 32'd512, 1}, '{10'd17, 32'd3, 32'd5, 32'd1024, 1},
            '{10'd18, 32'd3, 32'd5, 32'd1024, 1}, '{10'd18, 32'd3, 32'd5, 32'd0, 1}};
      for (int i = 0; i < 6; i++) begin
         do_cmd(v[i].f, v[i].a, v[i].b, r, lat);
         model_cmd(v[i].f, v[i].a, v[i].b, me, ml);
         n_cmp++; if (r !== v[i].e) begin n_bad++; $display("FAIL buf[%0d] rsp got %h want %h", i, r, v[i].e); end
         n_cmp++; if (lat != v[i].lat) begin n_bad++; $display("FAIL buf[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      end
   endtask

   task automatic test_oob;
      vec_t v[8];
      logic [31:0] r, me;
      int lat, ml;
      v = '{'{10'd17, 32'd28, 32'd0, 32'h80000000, 1}, '{10'd3, 32'd0, 32'd0, 32'd1, 1},
            '{10'd3, 32'd0, 32'd0, 32'd0, 1}, '{10'd17, 32'd4, 32'd0, 32'd512, 1},
            '{10'd18, 32'd3, 32'd28, 32'h80000000, 1}, '{10'd18, 32'd4, 32'd0, 32'd512, 1},
            '{10'd17, 32'd0, 32'hFFFFFFFF, 32'h80000000, 1}, '{10'd3, 32'd0, 32'd0, 32'd1, 1}};
      for (int i = 0; i < 8; i++) begin
         do_cmd(v[i].f, v[i].a, v[i].b, r, lat);
         model_cmd(v[i].f, v[i].a, v[i].b, me, ml);
         n_cmp++; if (r !== v[i].e) begin n_bad++; $display("FAIL oob[%0d] rsp got %h want %h", i, r, v[i].e); end
         n_cmp++; if (lat != v[i].lat) begin n_bad++; $display("FAIL oob[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      end
   endtask

   task automatic test_random;
      logic [9:0]  und [6];
      logic [9:0]  f;
      logic [31:0] a, b, r, e;
      int lat, el;
      und = '{10'd4, 10'd7, 10'd11, 10'd15, 10'd19, 10'h3ff};
      for (int i = 0; i < 300; i++) begin
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 9))
            0: begin f = 10'd9; b = $urandom_range(0, 20); end
            1: f = 10'd10;
            2, 3: f = 10'd1;
            4: f = 10'd2;
            5: f = 10'd3;
            6, 7: begin f = ($urandom_range(0, 1) == 0) ? 10'd17 : 10'd18; a = $urandom_range(0, 30); b = $urandom_range(0, 30); end
            8: f = und[$urandom_range(0, 5)];
            default: f = ($urandom_range(0, 3) == 0) ? 10'd8 : 10'd0;
         endcase
         do_cmd(f, a, b, r, lat);
         model_cmd(f, a, b, e, el);
         n_cmp++; if (r !== e) begin n_bad++; $display("FAIL rand[%0d] fn=%0d rsp got %h want %h", i, f, r, e); end
         n_cmp++; if (lat != el) begin n_bad++; $display("FAIL rand[%0d] fn=%0d latency got %0d want %0d", i, f, lat, el); end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] a, b, e;
      int el, g;
      a = $urandom; b = $urandom;
      model_cmd(10'd1, a, b, e, el);
      @(negedge clk);
      rsp_ready = 0; fn = 10'd1; in0 = a; in1 = b; cmd_valid = 1;
      g = 0;
      while (!cmd_ready && g < 2000) begin @(negedge clk); g++; end
      @(posedge clk); #1;
      cmd_valid = 0;
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_rise got %b want 1", rsp_valid); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, rsp_valid); end
         n_cmp++; if (rsp_out !== e) begin n_bad++; $display("FAIL bp_hold_data[%0d] got %h want %h", i, rsp_out, e); end
         n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d] got %b want 0", i, cmd_ready); end
      end
      @(negedge clk);
      rsp_ready = 1;
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done_valid got %b want 0", rsp_valid); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL bp_done_ready got %b want 1", cmd_ready); end
   endtask

   task automatic test_clear;
      logic [31:0] r, e, a, b;
      int lat, el;
      do_cmd(10'd17, 32'd7, 32'd7, r, lat);
      model_cmd(10'd17, 32'd7, 32'd7, e, el);
      n_cmp++; if (r !== e) begin n_bad++; $display("FAIL clr_seed got %h want %h", r, e); end
      do_cmd(10'd16, 32'd0, 32'd0, r, lat);
      model_cmd(10'd16, 32'd0, 32'd0, e, el);
      n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL clr_rsp got %h want 0", r); end
      n_cmp++; if (lat != R * C + 1) begin n_bad++; $display("FAIL clr_latency got %0d want %0d", lat, R * C + 1); end
      do_cmd(10'd18, 32'd7, 32'd7, r, lat);
      model_cmd(10'd18, 32'd7, 32'd7, e, el);
      n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL clr_entry got %h want 0", r); end
      for (int i = 0; i < 6; i++) begin
         a = $urandom_range(0, R - 1); b = $urandom_range(0, C - 1);
         do_cmd(10'd18, a, b, r, lat);
         model_cmd(10'd18, a, b, e, el);
         n_cmp++; if (r !== e) begin n_bad++; $display("FAIL clr_rand[%0d] got %h want %h", i, r, e); end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] r, e;
      int lat, el;
      do_cmd(10'd1, 32'h11223344, 32'h55667788, r, lat);
      model_cmd(10'd1, 32'h11223344, 32'h55667788, e, el);
      do_cmd(10'd17, 32'd2, 32'd2, r, lat);
      model_cmd(10'd17, 32'd2, 32'd2, e, el);
      n_cmp++; if (r !== e) begin n_bad++; $display("FAIL mid_seed got %h want %h", r, e); end
      start(10'd1, $urandom, $urandom);
      test_reset;
      do_cmd(10'd2, 32'd0, 32'd0, r, lat);
      n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL mid_mac_sum got %h want 0", r); end
      do_cmd(10'd18, 32'd2, 32'd2, r, lat);
      n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL mid_mac_buf got %h want 0", r); end
      start(10'd16, 32'd0, 32'd0);
      repeat (100) @(posedge clk);
      test_reset;
      start(10'd2, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      test_reset;
      do_cmd(10'd3, 32'd0, 32'd0, r, lat);
      n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL mid_rsp_err got %h want 0", r); end
   endtask

   initial begin
      test_reset;
      test_mac;
      test_buffer;
      test_oob;
      test_random;
      test_backpressure;
      test_clear;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
